// File: rtl/image_mem_arbiter_pkg.sv
// Shared image geometry and bus payload types for the display and processing blocks.
package image_mem_arbiter_pkg;

    localparam int unsigned IMG_WIDTH  = 160;
    localparam int unsigned IMG_HEIGHT = 148;
    localparam int unsigned IMG_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DATA_W     = 12;

    // One in-flight read: port 0 = display, 1 = processing.
    typedef struct packed {
        logic valid;
        logic port;
        logic range_ok;
    } rd_tag_t;

endpackage

// File: rtl/image_mem_arbiter_read_tag_pipe.sv
// Shift register that follows each granted read through the image_mem latency.
module read_tag_pipe
    import image_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_in,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t pipe [DEPTH];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/image_mem_arbiter.sv
// Two-port image_mem arbiter: display reads win, processing gets a forced slot after starving.
module image_mem_arbiter
    import image_mem_arbiter_pkg::rd_tag_t;
#(
    parameter int unsigned ADDR_W       = image_mem_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W       = image_mem_arbiter_pkg::DATA_W,
    parameter int unsigned IMG_PIXELS   = image_mem_arbiter_pkg::IMG_PIXELS,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_valid,
    output logic [DATA_W-1:0] p0_data,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_valid,
    output logic [DATA_W-1:0] p1_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              addr_err,
    output logic [15:0]       p0_stall_cnt
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned DEPTH    = 1 + MEM_LATENCY;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [15:0]         stall_d;
    logic [ADDR_W-1:0]   sel_addr;
    logic                gnt_any;
    logic                range_ok;
    logic                forced;
    rd_tag_t             tag_in, tag_out;

    // Arbitration and next-state; grants are held low while in reset.
    always_comb begin
        p0_gnt   = 1'b0;
        p1_gnt   = 1'b0;
        starve_d = starve_q;
        stall_d  = p0_stall_cnt;
        forced   = p1_req && (starve_q == STARVE_MAX);
        if (reset) begin
            if (p0_req && !forced) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
            if (!p1_req || p1_gnt) begin
                starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + STARVE_W'(1);
            end
            if (p0_req && !p0_gnt && (p0_stall_cnt != 16'hFFFF)) begin
                stall_d = p0_stall_cnt + 16'd1;
            end
        end
        gnt_any        = p0_gnt || p1_gnt;
        sel_addr       = p1_gnt ? p1_addr : p0_addr;
        range_ok       = 32'(sel_addr) < IMG_PIXELS;
        tag_in.valid    = gnt_any && !(p1_gnt && p1_we);
        tag_in.port     = p1_gnt;
        tag_in.range_ok = range_ok;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            starve_q     <= '0;
            p0_stall_cnt <= '0;
            mem_address  <= '0;
            mem_wren     <= 1'b0;
            mem_data     <= '0;
            addr_err     <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            p0_stall_cnt <= stall_d;
            mem_wren     <= p1_gnt && p1_we && range_ok;
            if (gnt_any) begin
                mem_address <= sel_addr;
            end
            if (p1_gnt && p1_we) begin
                mem_data <= p1_wdata;
            end
            if (gnt_any && !range_ok) begin
                addr_err <= 1'b1;
            end
        end
    end

    read_tag_pipe #(
        .DEPTH(DEPTH)
    ) u_tag_pipe (
        .clk_in (clk_in),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    // Return path: out-of-range reads complete with zero data.
    assign p0_valid = tag_out.valid && !tag_out.port;
    assign p1_valid = tag_out.valid && tag_out.port;
    assign p0_data  = (p0_valid && tag_out.range_ok) ? mem_q : '0;
    assign p1_data  = (p1_valid && tag_out.range_ok) ? mem_q : '0;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter: one latency-1 and one latency-2 instance.
module tb_image_mem_arbiter;

    logic        clk50 = 1'b0;
    logic        reset;
    logic        p0_req, p1_req, p1_we;
    logic [14:0] p0_addr, p1_addr;
    logic [11:0] p1_wdata;
    logic        p0_gnt, p0_valid, p1_gnt, p1_valid, mem_wren, addr_err;
    logic [11:0] p0_data, p1_data, mem_data, mem_q;
    logic [14:0] mem_address;
    logic [15:0] p0_stall_cnt;

    logic        b_p0_req, b_p1_req;
    logic [14:0] b_p0_addr, b_p1_addr;
    logic        b_p0_gnt, b_p0_valid, b_p1_gnt, b_p1_valid, b_mem_wren, b_addr_err;
    logic [11:0] b_p0_data, b_p1_data, b_mem_data, b_mem_q, b_q1;
    logic [14:0] b_mem_address;
    logic [15:0] b_p0_stall_cnt;

    logic [11:0] mem_a   [32768];
    logic        written [32768];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk50 = ~clk50;

    function automatic logic [11:0] memv(input int a);
        return 12'(a * 37 + 11);
    endfunction

    image_mem_arbiter #(.MEM_LATENCY(1)) u_dut (
        .clk_in(clk50), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_valid(p0_valid), .p0_data(p0_data),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_valid(p1_valid), .p1_data(p1_data),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q),
        .addr_err(addr_err), .p0_stall_cnt(p0_stall_cnt)
    );

    image_mem_arbiter #(.MEM_LATENCY(2)) u_dut2 (
        .clk_in(clk50), .reset(reset),
        .p0_req(b_p0_req), .p0_addr(b_p0_addr), .p0_gnt(b_p0_gnt), .p0_valid(b_p0_valid), .p0_data(b_p0_data),
        .p1_req(b_p1_req), .p1_we(1'b0), .p1_addr(b_p1_addr), .p1_wdata(12'h000),
        .p1_gnt(b_p1_gnt), .p1_valid(b_p1_valid), .p1_data(b_p1_data),
        .mem_address(b_mem_address), .mem_wren(b_mem_wren), .mem_data(b_mem_data), .mem_q(b_mem_q),
        .addr_err(b_addr_err), .p0_stall_cnt(b_p0_stall_cnt)
    );

    // Latency-1 image_mem model; unwritten words hold memv(addr).
    initial for (int i = 0; i < 32768; i++) written[i] = 1'b0;
    always @(posedge clk50) begin
        if (mem_wren) begin
            mem_a[mem_address]   <= mem_data;
            written[mem_address] <= 1'b1;
        end
        mem_q <= written[mem_address] ? mem_a[mem_address] : memv(int'(mem_address));
    end

    // Latency-2 read-only image_mem model.
    always @(posedge clk50) begin
        b_q1    <= memv(int'(b_mem_address));
        b_mem_q <= b_q1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; p0_req = 1'b1; p0_addr = 15'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 15'd0; p1_wdata = 12'h000;
        b_p0_req = 1'b0; b_p1_req = 1'b0; b_p0_addr = 15'd0; b_p1_addr = 15'd0;
        #2;
        chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        chk("rst_p0_valid", 32'(p0_valid), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_stall", 32'(p0_stall_cnt), 32'd0);

        // A: continuous p0 reads of addresses 0..5
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            if (i == 0) reset = 1'b1;
            p0_req = (i < 6); p0_addr = 15'(i);
            #1;
            chk("A_p0_gnt", 32'(p0_gnt), 32'(i < 6));
            chk("A_p0_valid", 32'(p0_valid), 32'(i >= 2));
            chk("A_p0_data", 32'(p0_data), (i >= 2) ? 32'(memv(i - 2)) : 32'd0);
            if (i >= 1) chk("A_mem_address", 32'(mem_address), (i <= 6) ? 32'(i - 1) : 32'd5);
        end

        // B: both ports reading continuously -> p1 forced every 9th cycle
        for (int s = 0; s < 18; s++) begin
            @(negedge clk50);
            p0_req = 1'b1; p0_addr = 15'd10;
            p1_req = 1'b1; p1_we = 1'b0; p1_addr = 15'd20;
            #1;
            chk("B_p1_gnt", 32'(p1_gnt), 32'((s % 9) == 8));
            chk("B_p0_gnt", 32'(p0_gnt), 32'((s % 9) != 8));
            chk("B_stall", 32'(p0_stall_cnt), 32'(s / 9));
            chk("B_p0_valid", 32'(p0_valid), 32'((s >= 2) && (((s - 2) % 9) != 8)));
            chk("B_p1_valid", 32'(p1_valid), 32'((s >= 2) && (((s - 2) % 9) == 8)));
            if (p1_valid) chk("B_p1_data", 32'(p1_data), 32'(memv(20)));
            if (p0_valid) chk("B_p0_data", 32'(p0_data), 32'(memv(10)));
        end
        @(negedge clk50); p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk50); #1;
        chk("B_stall_final", 32'(p0_stall_cnt), 32'd2);

        // C: p1 write 100 <- ABC then read it back
        @(negedge clk50); p1_req = 1'b1; p1_we = 1'b1; p1_addr = 15'd100; p1_wdata = 12'hABC; #1;
        chk("C_wr_gnt", 32'(p1_gnt), 32'd1);
        @(negedge clk50); p1_we = 1'b0; p1_wdata = 12'h000; #1;
        chk("C_rd_gnt", 32'(p1_gnt), 32'd1);
        chk("C_mem_wren", 32'(mem_wren), 32'd1);
        chk("C_mem_address", 32'(mem_address), 32'd100);
        chk("C_mem_data", 32'(mem_data), 32'hABC);
        @(negedge clk50); p1_req = 1'b0; #1;
        chk("C_wren_off", 32'(mem_wren), 32'd0);
        chk("C_no_wr_valid", 32'(p1_valid), 32'd0);
        @(negedge clk50); #1;
        chk("C_p1_valid", 32'(p1_valid), 32'd1);
        chk("C_p1_data", 32'(p1_data), 32'hABC);
        chk("C_addr_err", 32'(addr_err), 32'd0);

        // D: out-of-range write and read at IMG_PIXELS
        @(negedge clk50); p1_req = 1'b1; p1_we = 1'b1; p1_addr = 15'(23680); p1_wdata = 12'h555; #1;
        chk("D_wr_gnt", 32'(p1_gnt), 32'd1);
        @(negedge clk50); p1_we = 1'b0; #1;
        chk("D_rd_gnt", 32'(p1_gnt), 32'd1);
        chk("D_mem_wren", 32'(mem_wren), 32'd0);
        chk("D_addr_err", 32'(addr_err), 32'd1);
        @(negedge clk50); p1_req = 1'b0; #1;
        chk("D_mem_wren2", 32'(mem_wren), 32'd0);
        chk("D_no_wr_valid", 32'(p1_valid), 32'd0);
        @(negedge clk50); #1;
        chk("D_p1_valid", 32'(p1_valid), 32'd1);
        chk("D_p1_data", 32'(p1_data), 32'd0);
        @(negedge clk50); #1;
        chk("D_addr_err_held", 32'(addr_err), 32'd1);

        // E: reset one cycle after three back-to-back reads
        for (int s = 0; s < 3; s++) begin
            @(negedge clk50); p0_req = 1'b1; p0_addr = 15'(s + 1); #1;
            chk("E_p0_gnt", 32'(p0_gnt), 32'd1);
        end
        @(negedge clk50); p0_req = 1'b0; #1;
        chk("E_pre_valid", 32'(p0_valid), 32'd1);
        chk("E_pre_data", 32'(p0_data), 32'(memv(2)));
        reset = 1'b0; #1;
        chk("E_rst_p0_valid", 32'(p0_valid), 32'd0);
        chk("E_rst_p0_data", 32'(p0_data), 32'd0);
        chk("E_rst_mem_address", 32'(mem_address), 32'd0);
        chk("E_rst_mem_data", 32'(mem_data), 32'd0);
        chk("E_rst_addr_err", 32'(addr_err), 32'd0);
        chk("E_rst_stall", 32'(p0_stall_cnt), 32'd0);
        @(negedge clk50); reset = 1'b1; p0_req = 1'b1; p0_addr = 15'd4; #1;
        chk("E_first_gnt", 32'(p0_gnt), 32'd1);
        chk("E_no_stale_valid", 32'(p0_valid), 32'd0);
        @(negedge clk50); p0_req = 1'b0; #1;
        chk("E_no_valid_5", 32'(p0_valid), 32'd0);
        @(negedge clk50); #1;
        chk("E_new_valid", 32'(p0_valid), 32'd1);
        chk("E_new_data", 32'(p0_data), 32'(memv(4)));
        @(negedge clk50); #1;
        chk("E_valid_off", 32'(p0_valid), 32'd0);

        // F: latency-2 instance, alternating p0/p1 reads
        for (int s = 0; s < 8; s++) begin
            @(negedge clk50);
            b_p0_req = (s < 4) && ((s % 2) == 0);
            b_p1_req = (s < 4) && ((s % 2) == 1);
            b_p0_addr = 15'(30 + s); b_p1_addr = 15'(40 + s);
            #1;
            chk("F_p0_gnt", 32'(b_p0_gnt), 32'((s < 4) && ((s % 2) == 0)));
            chk("F_p1_gnt", 32'(b_p1_gnt), 32'((s < 4) && ((s % 2) == 1)));
            chk("F_p0_valid", 32'(b_p0_valid), 32'((s >= 3) && (s < 7) && (((s - 3) % 2) == 0)));
            chk("F_p1_valid", 32'(b_p1_valid), 32'((s >= 3) && (s < 7) && (((s - 3) % 2) == 1)));
            chk("F_p0_data", 32'(b_p0_data),
                ((s >= 3) && (s < 7) && (((s - 3) % 2) == 0)) ? 32'(memv(30 + s - 3)) : 32'd0);
            chk("F_p1_data", 32'(b_p1_data),
                ((s >= 3) && (s < 7) && (((s - 3) % 2) == 1)) ? 32'(memv(40 + s - 3)) : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_mem_arbiter.md
IMAGE_MEM_ARBITER -- requirements
Module: image_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W default 15, image_mem address width; DATA_W default 12, pixel width; IMG_PIXELS default 23680 (160x148), valid address count; MEM_LATENCY default 1, image_mem read latency (1 or 2); STARVE_LIMIT default 8, p1 wait cycles before forced grant.
REQ-002 SHALL have ports, clock and reset first: clk_in in 1 single clock; reset in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: p0_req in 1 display read request; p0_addr in ADDR_W display read address; p0_gnt out 1 display request accepted this cycle; p0_valid out 1 display read data valid; p0_data out DATA_W display read data.
REQ-004 SHALL have ports: p1_req in 1 processing request; p1_we in 1 1=write 0=read; p1_addr in ADDR_W; p1_wdata in DATA_W; p1_gnt out 1; p1_valid out 1; p1_data out DATA_W.
REQ-005 SHALL have ports: mem_address out ADDR_W; mem_wren out 1; mem_data out DATA_W; mem_q in DATA_W image_mem output.
REQ-006 SHALL have ports: addr_err out 1 sticky out-of-range flag; p0_stall_cnt out 16 saturating count of denied p0 cycles.

Function
REQ-007 SHALL accept at most one request per cycle; pN_gnt combinational from current req and arbiter state.
REQ-008 SHALL grant p0 when p0_req=1 and starvation counter < STARVE_LIMIT; otherwise grant p1 if p1_req=1.
REQ-009 SHALL keep a starvation counter: +1 each cycle p1_req=1 and p1_gnt=0; cleared on p1 grant or p1_req=0; saturates at STARVE_LIMIT.
REQ-010 SHALL, when counter = STARVE_LIMIT and p1_req=1, grant p1 even if p0_req=1 (forced grant), deny p0 that cycle.
REQ-011 SHALL increment p0_stall_cnt each cycle p0_req=1 and p0_gnt=0; saturate at 16'hFFFF.
REQ-012 SHALL register accepted address/data/wren onto mem_* one cycle after grant; mem_wren high exactly one cycle per accepted in-range write; mem_wren=0 otherwise.
REQ-013 SHALL hold mem_address at last value when idle.
REQ-014 SHALL assert pN_valid for one cycle exactly 1+MEM_LATENCY cycles after the grant cycle of an accepted read, with pN_data = mem_q that cycle; writes produce no valid.
REQ-015 SHALL track in-flight reads with a tag pipeline of depth 1+MEM_LATENCY carrying {valid, port, range_ok}; back-to-back grants every cycle supported, data returned in grant order.
REQ-016 SHALL treat address >= IMG_PIXELS as out of range: still granted; write suppressed (mem_wren=0); read returns valid with data 0; addr_err set and held until reset.
REQ-017 SHALL drive pN_data=0 when pN_valid=0.
REQ-018 SHALL ignore p1_we, p1_wdata when p1_req=0.

Reset
REQ-019 SHALL on reset=0 asynchronously clear: gnts, valids, data outputs, mem_address, mem_wren, mem_data, addr_err, p0_stall_cnt, starvation counter, tag pipeline.
REQ-020 SHALL, on reset mid-operation, discard all in-flight reads; no valid is emitted for requests granted before reset.
REQ-021 SHALL accept requests from the first clk_in edge after reset deasserts.

Structure
REQ-022 SHALL place IMG_WIDTH=160, IMG_HEIGHT=148, IMG_PIXELS, ADDR_W, DATA_W in the shared image package used by display and processing blocks.
REQ-023 SHALL implement the tag pipeline as sub-module read_tag_pipe (parameter DEPTH).
REQ-024 SHALL be instantiated between image_mem and its requesters, clocked by the pixel clock.

Verification
REQ-025 p0_req=1 continuous, addr 0..5, p1 idle, MEM_LATENCY=1 -> p0_gnt every cycle, p0_valid 2 cycles after each grant, data = memory contents in order.
REQ-026 p0_req and p1_req (read) continuous, STARVE_LIMIT=8 -> p1_gnt once every 9 cycles, p0 denied those cycles, p0_stall_cnt increments by 1 each.
REQ-027 p1 write addr 100 data 12'hABC, then p1 read addr 100 -> mem_wren one cycle, p1_valid data 12'hABC.
REQ-028 p1 write addr 23680, then read addr 23680 -> mem_wren stays 0, p1_valid with data 0, addr_err=1 until reset.
REQ-029 Three back-to-back p0 reads, reset=0 asserted one cycle after last grant -> all outputs 0 immediately, no p0_valid after reset release.
REQ-030 MEM_LATENCY=2, alternating p0/p1 reads -> valids 3 cycles after grants, routed to correct port.
